// File: rtl/gcn_transform_pkg.sv
// Shared sizing, vector type and controller state encoding for the GCN transformation stage.
// The dot-product unit and the aggregation stage import the same constants.
package gcn_transform_pkg;
  localparam int DATA_WIDTH   = 96;
  localparam int WIDTH_IN     = 5;
  localparam int WIDTH_OUT    = 16;
  localparam int NUM_NODES    = 6;
  localparam int NUM_FEAT_OUT = 3;
  localparam int ADDR_W       = $clog2(NUM_NODES * NUM_FEAT_OUT);
  localparam int ROW_W        = $clog2(NUM_NODES);
  localparam int COL_W        = $clog2(NUM_FEAT_OUT);

  typedef logic [DATA_WIDTH-1:0][WIDTH_IN-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    W_REQ,
    W_CAP,
    F_REQ,
    F_CAP,
    WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/transformation_addr_gen.sv
// Row/column counters for the column-major walk over the result matrix,
// with wrap flags and the flattened result address.
module transformation_addr_gen
  import gcn_transform_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              row_inc,
  input  logic              col_inc,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last_row,
  output logic              last_col,
  output logic [ADDR_W-1:0] waddr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (col_inc) begin
      row <= '0;
      col <= col + 1'b1;
    end else if (row_inc) begin
      row <= row + 1'b1;
    end
  end

  assign last_row = (row == ROW_W'(NUM_NODES - 1));
  assign last_col = (col == COL_W'(NUM_FEAT_OUT - 1));
  assign waddr    = ADDR_W'(row) * ADDR_W'(NUM_FEAT_OUT) + ADDR_W'(col);

endmodule

// File: rtl/transformation_controller.sv
// Sequences the 96-element dot-product unit over every (node, output-feature) pair,
// one weight column at a time, writing each product to the result memory.
//
// state | meaning
// IDLE  | waiting for start
// W_REQ | read weight column col
// W_CAP | latch weight column into dp_in2
// F_REQ | read feature row row
// F_CAP | latch feature row into dp_in1
// WRITE | present product to result sink, hold until res_ready
// DONE  | one-cycle completion pulse
module transformation_controller
  import gcn_transform_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 done,
  output logic                 busy,
  output logic                 w_ren,
  output logic [COL_W-1:0]     w_raddr,
  input  vec_t                 w_rdata,
  output logic                 f_ren,
  output logic [ROW_W-1:0]     f_raddr,
  input  vec_t                 f_rdata,
  output vec_t                 dp_in1,
  output vec_t                 dp_in2,
  input  logic [WIDTH_OUT-1:0] dp_prod,
  output logic                 res_wen,
  output logic [ADDR_W-1:0]    res_waddr,
  output logic [WIDTH_OUT-1:0] res_wdata,
  input  logic                 res_ready
);

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic                last_row, last_col;
  logic [ADDR_W-1:0]   waddr;
  logic                accept;

  assign accept = (state == WRITE) && res_ready;

  transformation_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state == IDLE) && start),
    .row_inc  (accept && !last_row),
    .col_inc  (accept && last_row && !last_col),
    .row      (row),
    .col      (col),
    .last_row (last_row),
    .last_col (last_col),
    .waddr    (waddr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = W_REQ;
      W_REQ: state_nxt = W_CAP;
      W_CAP: state_nxt = F_REQ;
      F_REQ: state_nxt = F_CAP;
      F_CAP: state_nxt = WRITE;
      WRITE: if (res_ready) begin
        if (!last_row)      state_nxt = F_REQ;
        else if (!last_col) state_nxt = W_REQ;
        else                state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers keep the dot-product inputs stable through a stalled WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_in1 <= '0;
      dp_in2 <= '0;
    end else begin
      if (state == W_CAP) dp_in2 <= w_rdata;
      if (state == F_CAP) dp_in1 <= f_rdata;
    end
  end

  always_comb begin
    done      = 1'b0;
    busy      = (state != IDLE);
    w_ren     = 1'b0;
    w_raddr   = '0;
    f_ren     = 1'b0;
    f_raddr   = '0;
    res_wen   = 1'b0;
    res_waddr = '0;
    res_wdata = '0;
    case (state)
      W_REQ: begin
        w_ren   = 1'b1;
        w_raddr = col;
      end
      F_REQ: begin
        f_ren   = 1'b1;
        f_raddr = row;
      end
      WRITE: begin
        res_wen   = 1'b1;
        res_waddr = waddr;
        res_wdata = dp_prod;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_transformation_controller.sv
// Self-checking bench for transformation_controller: memory and dot-product models,
// a result scoreboard, and one task per scenario.
module tb_transformation_controller;
  import gcn_transform_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 done, busy;
  logic                 w_ren, f_ren;
  logic [COL_W-1:0]     w_raddr;
  logic [ROW_W-1:0]     f_raddr;
  vec_t                 w_rdata = '0;
  vec_t                 f_rdata = '0;
  vec_t                 dp_in1, dp_in2;
  logic [WIDTH_OUT-1:0] dp_prod;
  logic                 res_wen;
  logic [ADDR_W-1:0]    res_waddr;
  logic [WIDTH_OUT-1:0] res_wdata;
  logic                 res_ready = 1'b1;

  transformation_controller dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .w_ren(w_ren), .w_raddr(w_raddr), .w_rdata(w_rdata),
    .f_ren(f_ren), .f_raddr(f_raddr), .f_rdata(f_rdata),
    .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_prod(dp_prod),
    .res_wen(res_wen), .res_waddr(res_waddr), .res_wdata(res_wdata),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  vec_t wmem [NUM_FEAT_OUT];
  vec_t fmem [NUM_NODES];
  int   wval [NUM_FEAT_OUT];
  int   fval [NUM_NODES];

  always @(posedge clk) begin
    if (w_ren) w_rdata <= wmem[w_raddr];
    if (f_ren) f_rdata <= fmem[f_raddr];
  end

  // Dot-product unit: modulo 2^16 accumulation.
  always_comb begin
    int acc;
    acc = 0;
    for (int i = 0; i < DATA_WIDTH; i++) acc += int'(dp_in1[i]) * int'(dp_in2[i]);
    dp_prod = acc[15:0];
  end

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH_OUT-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  wcount = 0;
  int  done_cnt = 0;
  int  done_cycle = -1;

  logic                 hold_pending = 1'b0;
  logic [ADDR_W-1:0]    held_addr;
  logic [WIDTH_OUT-1:0] held_data;

  // Scoreboard: accepted writes pop the queue; stalled writes must stay stable.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      total++;
      if (w_ren && f_ren) begin
        bad++;
        $display("FAIL ren_overlap got w_ren=%0b f_ren=%0b want not both", w_ren, f_ren);
      end
      if (hold_pending) begin
        total++;
        if (res_wen !== 1'b1 || res_waddr !== held_addr || res_wdata !== held_data) begin
          bad++;
          $display("FAIL hold_stable got wen=%0b addr=%0d data=%0d want wen=1 addr=%0d data=%0d",
                   res_wen, res_waddr, res_wdata, held_addr, held_data);
        end
      end
      hold_pending = 1'b0;
      if (res_wen === 1'b1) begin
        if (!res_ready) begin
          hold_pending = 1'b1;
          held_addr    = res_waddr;
          held_data    = res_wdata;
        end else begin
          wr_t e;
          wcount++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_write got addr=%0d data=%0d want no write", res_waddr, res_wdata);
          end else begin
            e = exp_q.pop_front();
            if (res_waddr !== e.addr || res_wdata !== e.data) begin
              bad++;
              $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                       res_waddr, res_wdata, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  task automatic load_and_expect();
    wr_t e;
    for (int c = 0; c < NUM_FEAT_OUT; c++)
      for (int i = 0; i < DATA_WIDTH; i++) wmem[c][i] = 5'(wval[c]);
    for (int r = 0; r < NUM_NODES; r++)
      for (int i = 0; i < DATA_WIDTH; i++) fmem[r][i] = 5'(fval[r]);
    for (int c = 0; c < NUM_FEAT_OUT; c++)
      for (int r = 0; r < NUM_NODES; r++) begin
        e.addr = ADDR_W'(r * NUM_FEAT_OUT + c);
        e.data = 16'((DATA_WIDTH * fval[r] * wval[c]) % 65536);
        exp_q.push_back(e);
      end
  endtask

  // Starts a pass and walks ncyc cycles, applying the requested disturbances.
  task automatic drive_pass(input int low_at, input int low_len, input int pulse1,
                            input int pulse2, input int rst_at, input int ncyc);
    done_cnt   = 0;
    done_cycle = -1;
    wcount     = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (k == low_at) res_ready = 1'b0;
      if (k == low_at + low_len) res_ready = 1'b1;
      start = (k == pulse1) || (k == pulse2);
      reset = (k == rst_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || w_ren !== 1'b0 || f_ren !== 1'b0 || res_wen !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got busy=%0b done=%0b w_ren=%0b f_ren=%0b wen=%0b want all 0",
               busy, done, w_ren, f_ren, res_wen);
    end
    total++;
    if (dp_in1 !== '0 || dp_in2 !== '0 || res_waddr !== '0 || res_wdata !== '0) begin
      bad++;
      $display("FAIL reset_data got waddr=%0d wdata=%0d dp_nonzero=%0b want 0",
               res_waddr, res_wdata, (dp_in1 != '0) || (dp_in2 != '0));
    end
  endtask

  task automatic check_pass(input string name, input int want_done);
    total++;
    if (done_cycle != want_done || done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done got cycle=%0d count=%0d want cycle=%0d count=1",
               name, done_cycle, done_cnt, want_done);
    end
    total++;
    if (wcount != 18 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_writes got %0d left=%0d want 18 left=0", name, wcount, exp_q.size());
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got busy=%0b want 0", name, busy);
    end
  endtask

  task automatic test_all_ones();
    foreach (wval[c]) wval[c] = 1;
    foreach (fval[r]) fval[r] = 1;
    load_and_expect();
    drive_pass(-1, 0, -1, -1, -1, 70);
    check_pass("all_ones", 61);
  endtask

  task automatic test_scaled();
    foreach (wval[c]) wval[c] = c + 1;
    foreach (fval[r]) fval[r] = r + 1;
    load_and_expect();
    total++;
    if (exp_q[17].data !== 16'd1728 || exp_q[17].addr !== 5'd17) begin
      bad++;
      $display("FAIL scaled_model got addr=%0d data=%0d want addr=17 data=1728",
               exp_q[17].addr, exp_q[17].data);
    end
    drive_pass(-1, 0, -1, -1, -1, 70);
    check_pass("scaled", 61);
  endtask

  task automatic test_wrap();
    foreach (wval[c]) wval[c] = 31;
    foreach (fval[r]) fval[r] = 31;
    load_and_expect();
    total++;
    if (exp_q[0].data !== 16'd26720) begin
      bad++;
      $display("FAIL wrap_model got %0d want 26720", exp_q[0].data);
    end
    drive_pass(-1, 0, -1, -1, -1, 70);
    check_pass("wrap", 61);
  endtask

  task automatic test_backpressure();
    foreach (wval[c]) wval[c] = c + 2;
    foreach (fval[r]) fval[r] = r + 3;
    load_and_expect();
    drive_pass(14, 5, -1, -1, -1, 75);
    check_pass("backpressure", 66);
  endtask

  task automatic test_start_ignored();
    foreach (wval[c]) wval[c] = 1;
    foreach (fval[r]) fval[r] = 2;
    load_and_expect();
    drive_pass(-1, 0, 20, 61, -1, 70);
    check_pass("restart_ignored", 61);
    load_and_expect();
    drive_pass(-1, 0, -1, -1, -1, 70);
    check_pass("restart_fresh", 61);
  endtask

  task automatic test_reset_mid_pass();
    int stray;
    foreach (wval[c]) wval[c] = 3;
    foreach (fval[r]) fval[r] = 1;
    load_and_expect();
    drive_pass(-1, 0, -1, -1, 30, 30);
    reset = 1'b1;
    total++;
    if (wcount != 8 || done_cnt != 0) begin
      bad++;
      $display("FAIL abort_progress got writes=%0d dones=%0d want writes=8 dones=0", wcount, done_cnt);
    end
    test_reset();
    reset = 1'b0;
    exp_q.delete();
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || res_wen !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL abort_quiet got active_cycles=%0d want 0", stray);
    end
    foreach (fval[r]) fval[r] = 2 * r;
    load_and_expect();
    drive_pass(-1, 0, -1, -1, -1, 70);
    check_pass("after_abort", 61);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_all_ones();
    test_scaled();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
